mem_port_arb3: RTL and testbench
================================

# mem_port_arb3

Three-requester round-robin arbiter sequencing one shared memory port in the 32-bit CPU. Requesters are instruction fetch (0), load/store (1) and debug/DMA (2). The block grants one requester at a time and drives the 2-bit select of the 3:1 word mux in front of the port. It issues a start pulse to the port and holds the grant until the port signals completion.

## Interface
- `TIMEOUT`, default 255: cycles allowed in WAIT before abort; only with `ARB_TIMEOUT_EN`.
- `CNT_WIDTH`, default 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_WIDTH.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  3  request per requester, level-sensitive, bit i = requester i.
- `grant`  out  3  one-hot grant, registered; 3'b000 when idle.
- `sel`  out  2  mux select, registered: 2'b00/01/10 for requester 0/1/2; 2'b11 never driven.
- `port_start`  out  1  one-cycle pulse opening a port transaction.
- `port_done`  in  1  one-cycle pulse from the port: transaction complete.
- `busy`  out  1  high from grant through release.
- `timeout_err`  out  1  one-cycle pulse on abort; constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- States: IDLE, START, WAIT.
- IDLE:
  - If req != 0, pick a winner by round-robin, searching upward from last_winner+1 mod 3.
  - Register grant, sel and busy=1; go to START.
  - Otherwise stay; grant=0, sel holds its last value.
- START: port_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On port_done: clear grant and busy, set last_winner to the current winner, go to IDLE.
- port_done is ignored in IDLE and START.
- A requester dropping req while granted does not release the grant; only port_done (or timeout) ends the transaction.
- Changes on req during START/WAIT have no effect until the next IDLE evaluation.
- sel is stable from grant assertion through release and while idle, so the mux output never glitches between transactions.
- Reset values:
  - grant=0, sel=2'b00, port_start=0, busy=0, timeout_err=0.
  - State IDLE; last_winner=2, so requester 0 wins first.
- Reset asserted mid-transaction returns to the reset values on the next edge. A port_done arriving after that reset is ignored.

## Timing
- req seen in IDLE at edge N: grant/sel/busy valid after edge N, port_start high in cycle N+1.
- port_done sampled at edge M: grant/busy low after M.
- IDLE re-arbitrates at M+1. Minimum gap between grants is 1 idle cycle; a new grant appears after edge M+1.
- Minimum transaction (done in first WAIT cycle): 3 cycles per grant.
- Fairness: with all three requesting continuously, the grant order is 0,1,2,0,...; no requester waits more than 2 transactions.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT with no port_done: pulse timeout_err for 1 cycle, clear grant/busy, advance last_winner, return to IDLE.
  - If port_done and the timeout occur in the same cycle, port_done wins and there is no error.
- Not defined: no counter; WAIT persists until port_done; timeout_err tied to 0.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/START/WAIT);
  - requester index constants REQ_IF=0, REQ_LS=1, REQ_DBG=2;
  - sel encodings SEL_IF=2'b00, SEL_LS=2'b01, SEL_DBG=2'b10.
- One sub-module, `rr_pick3`: combinational; inputs req[2:0] and last[1:0]; outputs any, a one-hot winner and a 2-bit index.
- The top level holds the FSM, output registers and the optional counter.

## Test plan
- Reset, then req=3'b111 held: grants 001,010,100,001 in order, with sel 00,01,10,00. Each grant is preceded by one port_start pulse. Drive port_done 2 cycles after each start.
- Single req=3'b010 at cycle 5: grant=010 and sel=01 after edge 5, port_start in cycle 6. port_done at 9 gives grant=0 after edge 9.
- req[0] drops in WAIT with no port_done: grant stays 001 until port_done, then returns to IDLE with no spurious start.
- Port_done pulsed in IDLE and in START: no state change, and the transaction still waits for a later done.
- With `ARB_TIMEOUT_EN` and TIMEOUT=4, port never responds: timeout_err pulses once after 4 WAIT cycles, grant clears, and the next pending requester is granted.
- Reset asserted during WAIT: all outputs return to 0/00 on the next edge, and after release requester 0 wins first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the three-requester memory port arbiter.
// The optional abort timer is enabled with the ARB_TIMEOUT_EN macro in mem_port_arb3.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam logic [1:0] REQ_IF  = 2'd0;
   localparam logic [1:0] REQ_LS  = 2'd1;
   localparam logic [1:0] REQ_DBG = 2'd2;

   localparam logic [1:0] SEL_IF  = 2'b00;
   localparam logic [1:0] SEL_LS  = 2'b01;
   localparam logic [1:0] SEL_DBG = 2'b10;

   // Round-robin successor over the three requesters (wraps 2 -> 0).
   function automatic logic [1:0] next_idx(input logic [1:0] i);
      case (i)
         REQ_IF:  return REQ_LS;
         REQ_LS:  return REQ_DBG;
         default: return REQ_IF;
      endcase
   endfunction

   function automatic logic [1:0] sel_of(input logic [1:0] i);
      case (i)
         REQ_IF:  return SEL_IF;
         REQ_LS:  return SEL_LS;
         default: return SEL_DBG;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_arb3_rr_pick3.sv
// Combinational round-robin picker: searches upward from last+1 (mod 3)
// and returns the first active requester as one-hot plus its mux index.
module rr_pick3
   import mem_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic       any,
   output logic [2:0] winner,
   output logic [1:0] index
);

   logic [1:0] cand;

   always_comb begin
      winner = 3'b000;
      index  = SEL_IF;
      cand   = next_idx(last);
      for (int k = 0; k < 3; k++) begin
         if (winner == 3'b000 && req[cand]) begin
            winner = 3'b001 << cand;
            index  = sel_of(cand);
         end
         cand = next_idx(cand);
      end
   end

   assign any = |req;

endmodule

// File: rtl/mem_port_arb3.sv
// Round-robin arbiter for the shared memory port: grant, start pulse, hold until done.
// Define ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module mem_port_arb3
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   output logic [2:0] grant,
   output logic [1:0] sel,
   output logic       port_start,
   input  logic       port_done,
   output logic       busy,
   output logic       timeout_err
);

   arb_state_t state;
   logic [1:0] last_winner;
   logic       pick_any;
   logic [2:0] pick_onehot;
   logic [1:0] pick_idx;

   rr_pick3 u_pick (
      .req    (req),
      .last   (last_winner),
      .any    (pick_any),
      .winner (pick_onehot),
      .index  (pick_idx)
   );

`ifdef ARB_TIMEOUT_EN
   logic [CNT_WIDTH-1:0] tmo_cnt;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= 3'b000;
         sel         <= SEL_IF;
         port_start  <= 1'b0;
         busy        <= 1'b0;
         last_winner <= REQ_DBG;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         port_start <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant      <= pick_onehot;
                  sel        <= pick_idx;
                  busy       <= 1'b1;
                  port_start <= 1'b1;
                  state      <= START;
               end
            end
            START: begin
`ifdef ARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               // sel keeps the winner's index, so it doubles as the round-robin pointer source
               if (port_done) begin
                  grant       <= 3'b000;
                  busy        <= 1'b0;
                  last_winner <= sel;
                  state       <= IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (tmo_cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                  grant       <= 3'b000;
                  busy        <= 1'b0;
                  last_winner <= sel;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arb3.sv
// Randomized transaction-level bench for mem_port_arb3 against a round-robin reference model.
// Handles both the default build and the ARB_TIMEOUT_EN build (TIMEOUT=4).
module tb_mem_port_arb3;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic [2:0] grant;
   logic [1:0] sel;
   logic       port_start;
   logic       port_done;
   logic       busy;
   logic       timeout_err;

`ifdef ARB_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 0;
`endif

   int n_vec = 0;
   int n_err = 0;
   int last_win;
   logic [1:0] exp_sel;

   always #5 clk = ~clk;

   mem_port_arb3 #(.TIMEOUT(4), .CNT_WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .sel         (sel),
      .port_start  (port_start),
      .port_done   (port_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] g, input logic [1:0] s,
                             input logic b, input logic ps, input logic te);
      check({tag, ".grant"}, {5'd0, grant}, {5'd0, g});
      check({tag, ".sel"}, {6'd0, sel}, {6'd0, s});
      check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
      check({tag, ".port_start"}, {7'd0, port_start}, {7'd0, ps});
      check({tag, ".timeout_err"}, {7'd0, timeout_err}, {7'd0, te});
   endtask

   // Reference: first requester found scanning last+1, last+2, last+3 (mod 3).
   function automatic int rr_winner(input logic [2:0] r, input int last);
      for (int k = 1; k <= 3; k++) begin
         int i;
         i = (last + k) % 3;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] next_req(input int mode, input logic [2:0] r);
      if (mode == 0) return r;
      if (mode == 1) return 3'b000;
      return 3'($urandom_range(0, 7));
   endfunction

   // One arbitration attempt starting from IDLE; waits = done-free WAIT cycles before done.
   task automatic run_txn(input logic [2:0] r, input int waits, input int mode, input bit spur);
      int         w;
      logic [2:0] oh;
      bit         aborted;
      req       = r;
      port_done = spur;
      w = rr_winner(r, last_win);
      @(negedge clk);
      if (w < 0) begin
         check_outs("idle", 3'b000, exp_sel, 1'b0, 1'b0, 1'b0);
         port_done = 1'b0;
         return;
      end
      oh      = 3'b001 << w;
      exp_sel = w[1:0];
      check_outs("grant", oh, exp_sel, 1'b1, 1'b1, 1'b0);
      port_done = spur;
      req       = next_req(mode, r);
      @(negedge clk);
      check_outs("start", oh, exp_sel, 1'b1, 1'b0, 1'b0);
      aborted = 1'b0;
      for (int k = 0; k < waits && !aborted; k++) begin
         port_done = 1'b0;
         req       = next_req(mode, r);
         @(negedge clk);
         if (TMO != 0 && k + 1 == TMO) begin
            check_outs("abort", 3'b000, exp_sel, 1'b0, 1'b0, 1'b1);
            aborted = 1'b1;
         end else begin
            check_outs("wait", oh, exp_sel, 1'b1, 1'b0, 1'b0);
         end
      end
      if (!aborted) begin
         port_done = 1'b1;
         req       = next_req(mode, r);
         @(negedge clk);
         check_outs("done", 3'b000, exp_sel, 1'b0, 1'b0, 1'b0);
      end
      port_done = 1'b0;
      last_win  = w;
   endtask

   initial begin
      reset     = 1'b1;
      req       = 3'b000;
      port_done = 1'b0;
      last_win  = 2;
      exp_sel   = 2'b00;
      @(negedge clk);
      @(negedge clk);
      check_outs("reset", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // All three requesting: order 0,1,2,0.
      for (int i = 0; i < 4; i++) run_txn(3'b111, 1, 0, 1'b0);
      run_txn(3'b000, 0, 0, 1'b0);
      run_txn(3'b010, 2, 0, 1'b0);
      // Requester drops req while granted; grant held until done, no spurious start after.
      run_txn(3'b001, 3, 1, 1'b0);
      run_txn(3'b000, 0, 0, 1'b0);
      // Stray done in IDLE, then in IDLE+START of a real transaction.
      run_txn(3'b000, 0, 0, 1'b1);
      run_txn(3'b100, 2, 2, 1'b1);
      // Long wait: exercises the abort path when the timer is built in.
      run_txn(3'b011, 6, 0, 1'b0);
      run_txn(3'b111, 3, 0, 1'b0);

      // Reset during WAIT, then a stale done, then requester 0 must win first.
      req = 3'b110;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_outs("rst_wait", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
      reset     = 1'b0;
      last_win  = 2;
      exp_sel   = 2'b00;
      req       = 3'b000;
      port_done = 1'b1;
      @(negedge clk);
      check_outs("stale_done", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
      port_done = 1'b0;
      run_txn(3'b111, 0, 0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         run_txn(3'($urandom_range(0, 7)), $urandom_range(0, 6), 2, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
